round_key_gen: RTL and testbench

//   Iterative AES-128 key schedule feeding AddRoundKey. Loads a 128-bit cipher key,

---
 rtl/aes_pkg.sv | 70 +++++++
 rtl/aes_sbox.sv | 15 +
 rtl/round_key_gen.sv | 112 +++++++++++
 tb/tb_round_key_gen.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants and helpers.
//   AES_KEY_W : cipher key / round key width in bits
//   AES_NR    : number of rounds for AES-128
//   sbox()    : AES S-box (GF(2^8) inverse followed by the affine transform)
//   rcon()    : round constant byte for round index 1..10
package aes_pkg;

    localparam int unsigned AES_KEY_W = 128;
    localparam int unsigned AES_NR    = 10;

    // Multiply by x modulo the AES polynomial x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (8'h1b & {8{a[7]}});
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Inverse as a^254 via a fixed addition chain; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        return gf_mul(x252, x2);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] i;
        i = gf_inv(a);
        return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]}
                 ^ {i[3:0], i[7:4]} ^ 8'h63;
    endfunction

    // Round constant is a pure function of the round index, so it has no state to drift.
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box, one byte. Shared by the key schedule (SubWord) and SubBytes.
//   data : input byte
//   sub  : substituted byte
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] data,
    output logic [7:0] sub
);

    always_comb begin
        sub = sbox(data);
    end

endmodule

// File: rtl/round_key_gen.sv
// Iterative AES-128 key schedule feeding AddRoundKey. Holds one round key at a time:
// round key 0 is the cipher key, each consumer advance produces the next round key.
//   clk, rst   : clock (rising edge), synchronous active-high reset
//   key_valid  : key_in valid; accepted when key_valid && key_ready
//   key_in     : cipher key, w0 = key_in[127:96] .. w3 = key_in[31:0]
//   key_ready  : idle, will accept a new key
//   rk_adv     : consumer took round_key, advance (ignored unless rk_valid)
//   rk_valid   : round_key / round_num valid
//   round_key  : current round key, same word order as key_in
//   round_num  : index of round_key, 0..NR
//   last_round : rk_valid && round_num == NR
module round_key_gen
    import aes_pkg::*;
#(
    parameter int unsigned NR = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_valid,
    input  logic [AES_KEY_W-1:0] key_in,
    output logic                 key_ready,
    input  logic                 rk_adv,
    output logic                 rk_valid,
    output logic [AES_KEY_W-1:0] round_key,
    output logic [3:0]           round_num,
    output logic                 last_round
);

    if (NR != AES_NR) begin : g_nr_check
        $error("round_key_gen: only NR = 10 (AES-128) is supported");
    end

    localparam logic [3:0] LAST_NUM = 4'(NR);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [AES_KEY_W-1:0] key_q, key_d;
    logic [3:0]           num_q, num_d;

    logic [31:0]          rot_word;
    logic [31:0]          sub_word;
    logic [31:0]          temp_word;
    logic [31:0]          n0, n1, n2, n3;

    // SubWord(RotWord(w3)): rotate left by one byte, then substitute each byte.
    assign rot_word = {key_q[23:0], key_q[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_subword
        aes_sbox u_sbox (
            .data (rot_word[8*i +: 8]),
            .sub  (sub_word[8*i +: 8])
        );
    end

    assign temp_word = sub_word ^ {rcon(num_q + 4'd1), 24'h000000};
    assign n0        = key_q[127:96] ^ temp_word;
    assign n1        = key_q[95:64]  ^ n0;
    assign n2        = key_q[63:32]  ^ n1;
    assign n3        = key_q[31:0]   ^ n2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            num_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            num_q   <= num_d;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        num_d   = num_q;
        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    key_d   = key_in;
                    num_d   = '0;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (rk_adv) begin
                    // Leaving the last round keeps key and index visible for debug.
                    if (num_q == LAST_NUM) begin
                        state_d = IDLE;
                    end else begin
                        key_d = {n0, n1, n2, n3};
                        num_d = num_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        key_ready  = (state_q == IDLE);
        rk_valid   = (state_q == ACTIVE);
        round_key  = key_q;
        round_num  = num_q;
        last_round = (state_q == ACTIVE) && (num_q == LAST_NUM);
    end

endmodule

// File: tb/tb_round_key_gen.sv
module tb_round_key_gen;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic [127:0] key_in;
    logic         key_ready;
    logic         rk_adv;
    logic         rk_valid;
    logic [127:0] round_key;
    logic [3:0]   round_num;
    logic         last_round;

    always #5 clk = ~clk;

    round_key_gen #(.NR(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_in     (key_in),
        .key_ready  (key_ready),
        .rk_adv     (rk_adv),
        .rk_valid   (rk_valid),
        .round_key  (round_key),
        .round_num  (round_num),
        .last_round (last_round)
    );

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] OTHER_KEY = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    localparam logic [127:0] OTHER_RK10 = 128'h13111d7f_e3944a17_f307a78b_4d2b30c5;

    logic [127:0] fips_rk [0:10];

    typedef struct {
        logic [127:0] key;
        int           num;
        logic         valid;
        logic         ready;
        logic         last;
        logic         known;
    } exp_t;

    typedef struct {
        logic         kv;
        logic [127:0] k;
        logic         adv;
        logic         r;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[14];

    int unsigned tests = 0;
    int unsigned fails = 0;

    // Reference model state: keys come from the published FIPS-197 schedule table.
    logic         m_active;
    int           m_num;
    logic [127:0] m_key;
    logic         m_known;

    task automatic cycle(input logic kv, input logic [127:0] k, input logic adv,
                         input logic r, input string name);
        exp_t e;
        exp_t g;
        key_valid = kv;
        key_in    = k;
        rk_adv    = adv;
        rst       = r;
        if (r) begin
            m_active = 1'b0; m_num = 0; m_key = '0; m_known = 1'b1;
        end else if (!m_active) begin
            if (kv) begin
                m_active = 1'b1; m_num = 0; m_key = k; m_known = (k == FIPS_KEY);
            end
        end else if (adv) begin
            if (m_num == 10) begin
                m_active = 1'b0;
            end else begin
                m_num = m_num + 1;
                m_key = m_known ? fips_rk[m_num] : '0;
            end
        end
        e.key = m_key; e.num = m_num; e.valid = m_active; e.ready = !m_active;
        e.last = m_active && (m_num == 10); e.known = m_known;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        tests++;
        if ((round_num !== 4'(g.num)) || (rk_valid !== g.valid) || (key_ready !== g.ready) ||
            (last_round !== g.last) || (g.known && (round_key !== g.key))) begin
            fails++;
            $display("FAIL %s: got key=%h num=%0d valid=%b ready=%b last=%b, expected key=%h(known=%b) num=%0d valid=%b ready=%b last=%b",
                     name, round_key, round_num, rk_valid, key_ready, last_round,
                     g.key, g.known, g.num, g.valid, g.ready, g.last);
        end
    endtask

    task automatic check_val(input string name, input logic [127:0] got, input logic [127:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    initial begin
        fips_rk[0]  = FIPS_KEY;
        fips_rk[1]  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
        fips_rk[2]  = 128'hf2c295f2_7a96b943_5935807a_7359f67f;
        fips_rk[3]  = 128'h3d80477d_4716fe3e_1e237e44_6d7a883b;
        fips_rk[4]  = 128'hef44a541_a8525b7f_b671253b_db0bad00;
        fips_rk[5]  = 128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc;
        fips_rk[6]  = 128'h6d88a37a_110b3efd_dbf98641_ca0093fd;
        fips_rk[7]  = 128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f;
        fips_rk[8]  = 128'head27321_b58dbad2_312bf560_7f8d292f;
        fips_rk[9]  = 128'hac7766f3_19fadc21_28d12941_575c006e;
        fips_rk[10] = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;

        // Load (rk_adv ignored while idle), hold, then advance through all rounds and past.
        vecs[0] = '{kv: 1'b1, k: FIPS_KEY, adv: 1'b1, r: 1'b0};
        vecs[1] = '{kv: 1'b0, k: '0,       adv: 1'b0, r: 1'b0};
        for (int i = 2; i < 14; i++) vecs[i] = '{kv: 1'b0, k: '0, adv: 1'b1, r: 1'b0};

        m_active = 1'b0; m_num = 0; m_key = '0; m_known = 1'b1;
        key_valid = 1'b0; key_in = '0; rk_adv = 1'b0; rst = 1'b1;

        cycle(1'b0, '0, 1'b0, 1'b1, "reset");
        cycle(1'b1, FIPS_KEY, 1'b1, 1'b1, "reset_wins");
        cycle(1'b0, '0, 1'b0, 1'b0, "idle");

        for (int i = 0; i < 14; i++) cycle(vecs[i].kv, vecs[i].k, vecs[i].adv, vecs[i].r, $sformatf("vec%0d", i));
        check_val("rk10_hold_after_done", round_key, fips_rk[10]);

        // Back-pressure at round 4.
        cycle(1'b1, FIPS_KEY, 1'b0, 1'b0, "bp_load");
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0, "bp_adv");
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0, 1'b0, "bp_hold");
        for (int i = 0; i < 7; i++) cycle(1'b0, '0, 1'b1, 1'b0, "bp_resume");

        // New key offered mid-schedule must be ignored.
        cycle(1'b1, FIPS_KEY, 1'b0, 1'b0, "ign_load");
        cycle(1'b0, '0, 1'b1, 1'b0, "ign_adv");
        cycle(1'b0, '0, 1'b1, 1'b0, "ign_adv");
        for (int i = 0; i < 3; i++) cycle(1'b1, OTHER_KEY, 1'b1, 1'b0, "ign_key");
        cycle(1'b1, OTHER_KEY, 1'b0, 1'b0, "ign_key_hold");
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, 1'b0, "ign_finish");

        // Reset at round 6, then reload.
        cycle(1'b1, FIPS_KEY, 1'b0, 1'b0, "rst_load");
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, 1'b0, "rst_adv");
        cycle(1'b1, OTHER_KEY, 1'b1, 1'b1, "rst_mid");
        cycle(1'b1, FIPS_KEY, 1'b0, 1'b0, "reload");
        cycle(1'b0, '0, 1'b1, 1'b0, "reload_rk1");
        check_val("rk1_after_reload", round_key, 128'ha0fafe17_88542cb1_23a33939_2a6c7605);

        // AddRoundKey chain with rk1.
        check_val("add_round_key", 128'h046681e5_e0cb199a_48f8d37a_2806264c ^ round_key,
                  128'ha49c7ff2_689f352b_6b5bea43_026a5049);
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, 1'b0, "reload_finish");

        // Second key (FIPS-197 Appendix C.1): final round key only.
        cycle(1'b1, OTHER_KEY, 1'b0, 1'b0, "c1_load");
        check_val("c1_rk0", round_key, OTHER_KEY);
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, 1'b0, "c1_adv");
        check_val("c1_rk10", round_key, OTHER_RK10);
        cycle(1'b0, '0, 1'b1, 1'b0, "c1_done");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
